mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//  Sits beside the ALU in the execute stage.
//  Operands come from the register-file RS/RT read ports.
//  hi_o/lo_o feed the write-back select mux for MFHI/MFLO.
//  Decoder/control stalls the PC while busy_o is high.
// PARAMETERS
//  WIDTH   32   operand width; product and {HI,LO} are 2*WIDTH; CALC lasts WIDTH cycles
// PORTS
//  clk_i       in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start_i     in   1        launch op_i on src1_i/src2_i; accepted only in IDLE
//  op_i        in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  src1_i      in   WIDTH    RS operand (multiplicand / dividend)
//  src2_i      in   WIDTH    RT operand (multiplier / divisor)
//  hi_we_i     in   1        MTHI: HI <= wdata_i (IDLE only)
//  lo_we_i     in   1        MTLO: LO <= wdata_i (IDLE only)
//  wdata_i     in   WIDTH    write data for MTHI/MTLO
//  busy_o      out  1        1 while state != IDLE
//  done_o      out  1        one-cycle pulse when result committed
//  div_zero_o  out  1        pulses with done_o when a DIV/DIVU had src2_i == 0
//  hi_o        out  WIDTH    HI register
//  lo_o        out  WIDTH    LO register
// BEHAVIOUR
//  Reset: async on rst_n low.
//   - State IDLE, count 0.
//   - hi_o=0, lo_o=0, busy_o=0, done_o=0, div_zero_o=0, all datapath regs 0.
//  FSM IDLE -> CALC -> FIX -> IDLE. Edge numbering: edge 0 is the edge sampling start_i.
//   IDLE: on start_i, latch op and operands.
//    - Signed ops (MULT/DIV) latch |src1|, |src2| and record the sign flags.
//    - |-2^(W-1)| = 2^(W-1) as unsigned.
//    - Go to CALC, count=0.
//   CALC: one radix-2 step per edge, count 0..WIDTH-1; to FIX after the WIDTH-th step.
//    - Multiply: shift-add into a 2W accumulator.
//    - Divide: restoring shift-subtract.
//   FIX, one edge:
//    - Apply sign correction.
//    - Write HI/LO, set done_o=1, go to IDLE.
//  Latency: done_o and updated hi_o/lo_o are visible after edge WIDTH+1 (33 for W=32).
//   - busy_o is high after edge 0 through edge WIDTH+1, and falls in the same cycle done_o rises.
//   - done_o is cleared on the next edge.
//  Results:
//   - MULT/MULTU: {HI,LO} = product. MULT negates the 2W product if operand signs differ.
//   - DIV/DIVU: LO = quotient, HI = remainder.
//   - DIV signs: quotient negated if operand signs differ; remainder takes the dividend sign (truncating).
//   - DIV -2^(W-1) / -1: LO = 0x80000000 (wraps), HI = 0. No flag.
//  Divide by zero:
//   - Same latency.
//   - HI/LO left unchanged.
//   - div_zero_o=1 together with done_o.
//  Boundary rules:
//   - start_i while busy: ignored; no re-latch, no effect on the op in flight.
//   - hi_we_i/lo_we_i while busy: ignored.
//   - start_i and hi_we_i/lo_we_i in the same IDLE edge: the write happens and the op starts. The op result later overwrites HI/LO.
//   - hi_we_i and lo_we_i together: both written with wdata_i.
//   - Reset mid-CALC/FIX: abort. No done_o; HI/LO cleared.
//   - Operands are sampled only at edge 0; src changes during CALC have no effect.
// TESTING
//  1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done_o exactly at edge 33, busy_o 1 for 33 cycles.
//  2 MULT 0xFFFFFFFD(-3)*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  3 DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4 MTHI 0x1234, MTLO 0x5678, then DIVU 5/0 -> done_o and div_zero_o at edge 33; HI=0x1234, LO=0x5678 unchanged.
//  5 MULTU 3*4, then start_i DIVU 9/3 and hi_we_i at edge 5 -> both ignored; final HI=0, LO=12; single done_o pulse.
//  6 rst_n low at edge 10 of a MULTU -> busy_o=0, hi_o=lo_o=0 immediately (async); no done_o; next op after release completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Signed ops run on magnitudes; signs are applied in a single FIX cycle after WIDTH CALC steps.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dz_pend_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               div_zero_q;

  logic               s1_neg_d, s2_neg_d;
  logic [WIDTH-1:0]   abs1_d, abs2_d;
  logic [WIDTH:0]     mul_sum_d, div_rem_d, div_diff_d;
  logic [2*WIDTH-1:0] acc_mul_d, acc_div_d, fix_prod_d;
  logic [WIDTH-1:0]   fix_quo_d, fix_rem_d;

  always_comb begin
    s1_neg_d = op_i[0] & src1_i[WIDTH-1];
    s2_neg_d = op_i[0] & src2_i[WIDTH-1];
    // Negating the most negative value yields 2^(WIDTH-1) as an unsigned magnitude.
    abs1_d   = s1_neg_d ? ('0 - src1_i) : src1_i;
    abs2_d   = s2_neg_d ? ('0 - src2_i) : src2_i;

    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_mul_d = {mul_sum_d, acc_q[WIDTH-1:1]};

    // Divide: the upper half is the partial remainder, the lower half shifts dividend out and quotient in.
    div_rem_d  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_d = div_rem_d - {1'b0, a_q};
    if (div_diff_d[WIDTH])
      acc_div_d = {div_rem_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      acc_div_d = {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    fix_prod_d = neg_res_q ? ('0 - acc_q) : acc_q;
    fix_quo_d  = neg_res_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    fix_rem_d  = neg_rem_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      a_q        <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i) begin
            is_div_q  <= op_i[1];
            a_q       <= op_i[1] ? abs2_d : abs1_d;
            acc_q     <= {{WIDTH{1'b0}}, (op_i[1] ? abs1_d : abs2_d)};
            neg_res_q <= s1_neg_d ^ s2_neg_d;
            neg_rem_q <= s1_neg_d;
            dz_pend_q <= op_i[1] & (src2_i == '0);
            count_q   <= '0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_q   <= is_div_q ? acc_div_d : acc_mul_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          if (!is_div_q) begin
            hi_q <= fix_prod_d[2*WIDTH-1:WIDTH];
            lo_q <= fix_prod_d[WIDTH-1:0];
          end else if (!dz_pend_q) begin
            hi_q <= fix_rem_d;
            lo_q <= fix_quo_d;
          end
          done_q     <= 1'b1;
          div_zero_q <= dz_pend_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
endmodule
